mole_round_controller: RTL and testbench

Round sequencer for the mole game: on a start request it runs a fixed number of rounds, each a dark gap followed by a timed mole appearance at a pseudo-random key position 1..12. It consumes the registered `button_pressed`/`button_value` outputs of the key decoder, converts presses to single press events, judges each round as hit or miss, and keeps score. It sits between the key decoder and the LED/FND display logic.

---
 rtl/mole_game_pkg.sv | 29 ++
 rtl/mole_lfsr16.sv | 17 +
 rtl/mole_round_controller.sv | 126 ++++++++++++
 tb/tb_mole_round_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_game_pkg.sv
// Shared types and helpers for the mole game: FSM states, key/score widths
// and the mapping from LFSR bits to a mole key position.
package mole_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SHOW,
    ST_RESULT,
    ST_DONE
  } state_t;

  localparam int NUM_KEYS = 12;
  localparam int KEY_W    = 4;
  localparam int SCORE_W  = 8;

  // Folds the low nibble onto keys 1..12 and never repeats the previous key.
  function automatic logic [KEY_W-1:0] map_position(input logic [15:0] lfsr,
                                                    input logic [KEY_W-1:0] prev);
    logic [KEY_W-1:0] v;
    logic [KEY_W-1:0] p;
    v = lfsr[KEY_W-1:0];
    p = (v < KEY_W'(NUM_KEYS)) ? v + KEY_W'(1) : v - KEY_W'(NUM_KEYS - 1);
    if (p == prev)
      p = (p == KEY_W'(NUM_KEYS)) ? KEY_W'(1) : p + KEY_W'(1);
    return p;
  endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11.
module mole_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_1MHz,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n)
      state <= SEED;
    else
      state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/mole_round_controller.sv
// Round sequencer for the mole game: gap/show timing, press-event judging,
// scoring and round counting, with a free-running LFSR choosing positions.
module mole_round_controller
  import mole_game_pkg::*;
#(
  parameter int          SHOW_CYCLES = 500_000,
  parameter int          GAP_CYCLES  = 200_000,
  parameter int          ROUNDS      = 20,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk_1MHz,
  input  logic               rst_n,
  input  logic               start,
  input  logic               button_pressed,
  input  logic [KEY_W-1:0]   button_value,
  output logic               mole_on,
  output logic [KEY_W-1:0]   mole_pos,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         round_cnt,
  output logic               busy,
  output logic               game_done
);

  localparam int TW = $clog2((SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES);

  state_t           state;
  logic [TW-1:0]    timer;
  logic [KEY_W-1:0] last_pos;
  logic             start_q;
  logic             pressed_q;
  logic [15:0]      lfsr;
  logic             start_evt;
  logic             press_evt;
  logic [KEY_W-1:0] next_pos;

  mole_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .state    (lfsr)
  );

  // A held key or start level produces exactly one event at its rising edge.
  assign start_evt = start & ~start_q;
  assign press_evt = button_pressed & ~pressed_q;
  assign next_pos  = map_position(lfsr, last_pos);

  // NOTE: every register here is assigned with <= so all next-state values are
  // computed from the pre-edge state, regardless of statement order.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      last_pos   <= '0;
      start_q    <= 1'b0;
      pressed_q  <= 1'b0;
      mole_on    <= 1'b0;
      mole_pos   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      round_cnt  <= '0;
      busy       <= 1'b0;
      game_done  <= 1'b0;
    end else begin
      start_q    <= start;
      pressed_q  <= button_pressed;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_evt) begin
            score     <= '0;
            round_cnt <= '0;
            game_done <= 1'b0;
            busy      <= 1'b1;
            last_pos  <= '0;
            timer     <= TW'(GAP_CYCLES - 1);
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer == '0) begin
            timer    <= TW'(SHOW_CYCLES - 1);
            mole_on  <= 1'b1;
            mole_pos <= next_pos;
            last_pos <= next_pos;
            state    <= ST_SHOW;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_SHOW: begin
          // A press on the expiry cycle wins over the timeout.
          if (press_evt || timer == '0) begin
            mole_on  <= 1'b0;
            mole_pos <= '0;
            state    <= ST_RESULT;
            if (press_evt && button_value == mole_pos) begin
              hit_pulse <= 1'b1;
              score     <= score + SCORE_W'(1);
            end else begin
              miss_pulse <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_RESULT: begin
          round_cnt <= round_cnt + 8'd1;
          if (round_cnt + 8'd1 == 8'(ROUNDS)) begin
            busy      <= 1'b0;
            game_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            timer <= TW'(GAP_CYCLES - 1);
            state <= ST_GAP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_controller.sv
// Randomized bench for mole_round_controller: a round-level script model
// predicts every output on every cycle and checks the DUT against it.
module tb_mole_round_controller;

  localparam int          SHOW   = 8;
  localparam int          GAP    = 4;
  localparam int          ROUNDS = 3;
  localparam logic [15:0] SEED   = 16'hACE1;

  localparam int M_NONE       = 0;
  localparam int M_HIT        = 1;
  localparam int M_WRONG      = 2;
  localparam int M_GAP_PRESS  = 3;
  localparam int M_HOLD       = 4;
  localparam int M_START_BUSY = 5;

  logic       clk_1MHz = 1'b0;
  logic       rst_n;
  logic       start;
  logic       button_pressed;
  logic [3:0] button_value;
  logic       mole_on;
  logic [3:0] mole_pos;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score;
  logic [7:0] round_cnt;
  logic       busy;
  logic       game_done;

  mole_round_controller #(
    .SHOW_CYCLES (SHOW),
    .GAP_CYCLES  (GAP),
    .ROUNDS      (ROUNDS),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk_1MHz       (clk_1MHz),
    .rst_n          (rst_n),
    .start          (start),
    .button_pressed (button_pressed),
    .button_value   (button_value),
    .mole_on        (mole_on),
    .mole_pos       (mole_pos),
    .hit_pulse      (hit_pulse),
    .miss_pulse     (miss_pulse),
    .score          (score),
    .round_cnt      (round_cnt),
    .busy           (busy),
    .game_done      (game_done)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_lfsr;
  int last_pos;
  int exp_on, exp_pos, exp_hit, exp_miss, exp_score, exp_round, exp_busy, exp_done;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Position rule applied to the generator value present at the latching edge.
  function automatic int pos_model();
    int v, p;
    v = int'(ref_lfsr[3:0]);
    p = (v < 12) ? v + 1 : v - 11;
    if (p == last_pos) p = p % 12 + 1;
    return p;
  endfunction

  function automatic int wrong_key(input int p);
    return (p - 1 + int'($urandom_range(1, 11))) % 12 + 1;
  endfunction

  task automatic check_all();
    check("mole_on",    32'(mole_on),    32'(exp_on));
    check("mole_pos",   32'(mole_pos),   32'(exp_pos));
    check("hit_pulse",  32'(hit_pulse),  32'(exp_hit));
    check("miss_pulse", 32'(miss_pulse), 32'(exp_miss));
    check("score",      32'(score),      32'(exp_score));
    check("round_cnt",  32'(round_cnt),  32'(exp_round));
    check("busy",       32'(busy),       32'(exp_busy));
    check("game_done",  32'(game_done),  32'(exp_done));
  endtask

  task automatic step();
    @(posedge clk_1MHz);
    if (rst_n) ref_lfsr = lfsr_next(ref_lfsr);
    #1;
    check_all();
  endtask

  task automatic clear_expect();
    exp_on = 0; exp_pos = 0; exp_hit = 0; exp_miss = 0;
    exp_score = 0; exp_round = 0; exp_busy = 0; exp_done = 0;
  endtask

  task automatic start_game();
    start = 1'b1;
    exp_busy = 1; exp_done = 0; exp_score = 0; exp_round = 0;
    last_pos = 0;
    step();
    start = 1'b0;
  endtask

  // Dark gap; the last edge of the loop is where the mole appears.
  task automatic gap_phase(input int mode, output int p);
    p = 0;
    for (int i = 0; i < GAP; i++) begin
      button_pressed = (mode == M_GAP_PRESS && i == 1) || (mode == M_HOLD && i >= 1);
      button_value   = 4'($urandom_range(1, 12));
      start          = (mode == M_START_BUSY && i == 1);
      if (i == GAP - 1) begin
        p = pos_model();
        last_pos = p;
        exp_on = 1;
        exp_pos = p;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic run_round(input int mode, input int off);
    int  p;
    bit  resolved;
    gap_phase(mode, p);
    resolved = 1'b0;
    for (int j = 0; j < SHOW && !resolved; j++) begin
      button_pressed = (mode == M_HOLD);
      if ((mode == M_HIT || mode == M_WRONG) && j == off) begin
        button_pressed = 1'b1;
        button_value   = (mode == M_HIT) ? 4'(p) : 4'(wrong_key(p));
        exp_hit  = (mode == M_HIT) ? 1 : 0;
        exp_miss = (mode == M_WRONG) ? 1 : 0;
        if (mode == M_HIT) exp_score++;
        resolved = 1'b1;
      end else if (j == SHOW - 1) begin
        exp_miss = 1;
        resolved = 1'b1;
      end
      if (resolved) begin
        exp_on = 0;
        exp_pos = 0;
      end
      step();
    end
    button_pressed = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    exp_round++;
    if (exp_round == ROUNDS) begin
      exp_busy = 0;
      exp_done = 1;
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int p;
    rst_n = 1'b0;
    start = 1'b0;
    button_pressed = 1'b0;
    button_value = 4'd0;
    ref_lfsr = SEED;
    last_pos = 0;
    clear_expect();
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // No keys at all: three timeouts.
    start_game();
    for (int r = 0; r < ROUNDS; r++) run_round(M_NONE, 0);
    idle(3);

    // Correct key on the third visible cycle each round.
    start_game();
    for (int r = 0; r < ROUNDS; r++) run_round(M_HIT, 2);
    idle(2);

    // Wrong key, press during gap, key held from gap into show.
    start_game();
    run_round(M_WRONG, 4);
    run_round(M_GAP_PRESS, 0);
    run_round(M_HOLD, 0);
    idle(2);

    // Hit on the expiry cycle, start pulse while busy, immediate hit.
    start_game();
    run_round(M_HIT, SHOW - 1);
    run_round(M_START_BUSY, 0);
    run_round(M_HIT, 0);
    idle(2);

    // Randomized games.
    for (int g = 0; g < 8; g++) begin
      start_game();
      for (int r = 0; r < ROUNDS; r++)
        run_round(int'($urandom_range(0, 5)), int'($urandom_range(0, SHOW - 1)));
      idle(int'($urandom_range(1, 4)));
    end

    // Asynchronous reset in the middle of a visible mole.
    start_game();
    gap_phase(M_NONE, p);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    clear_expect();
    check_all();
    idle(2);
    rst_n = 1'b1;
    ref_lfsr = SEED;
    last_pos = 0;
    idle(3);

    // Full game after reset: positions follow the reseeded generator.
    start_game();
    for (int r = 0; r < ROUNDS; r++)
      run_round(int'($urandom_range(0, 5)), int'($urandom_range(0, SHOW - 1)));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
